// File: rtl/tetris_pkg.sv
// Shared piece IDs and scheduler state encoding for the tetromino pipeline.
package tetris_pkg;

    localparam int PIECE_W = 3;

    localparam logic [PIECE_W-1:0] PIECE_NONE = 3'd0;
    localparam logic [PIECE_W-1:0] PIECE_I    = 3'd1;
    localparam logic [PIECE_W-1:0] PIECE_J    = 3'd2;
    localparam logic [PIECE_W-1:0] PIECE_L    = 3'd3;
    localparam logic [PIECE_W-1:0] PIECE_O    = 3'd4;
    localparam logic [PIECE_W-1:0] PIECE_S    = 3'd5;
    localparam logic [PIECE_W-1:0] PIECE_T    = 3'd6;
    localparam logic [PIECE_W-1:0] PIECE_Z    = 3'd7;

    typedef enum logic {
        S_FILL,
        S_FULL
    } sched_state_t;

endpackage

// File: rtl/piece_fifo.sv
// Shift-register piece queue: head in slot 0, push lands just above the
// surviving entries, pop shifts everything down and clears the top slot.
module piece_fifo #(
    parameter int DEPTH = 3,
    parameter int PW    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [PW-1:0]     wdata,
    output logic [PW*DEPTH-1:0] slots,
    output logic [2:0]        count
);

    logic [PW-1:0] mem      [DEPTH];
    logic [PW-1:0] mem_next [DEPTH];
    logic [2:0]    count_next;
    logic [2:0]    wr_idx;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        mem_next   = mem;
        count_next = count;
        wr_idx     = count - {2'b00, pop};
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_next[i] = mem[i+1];
            end
            mem_next[DEPTH-1] = '0;
            count_next        = count - 3'd1;
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (3'(i) == wr_idx) begin
                    mem_next[i] = wdata;
                end
            end
            count_next = count_next + 3'd1;
        end
    end

    // NOTE: the storage is reset, not just the count, because empty slots
    // are visible on the preview bus and must read as "no piece".
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            count <= 3'd0;
        end else begin
            mem   <= mem_next;
            count <= count_next;
        end
    end

    always_comb begin
        slots = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slots[i*PW +: PW] = mem[i];
        end
    end

endmodule

// File: rtl/piece_scheduler.sv
// Samples the free-running piece counter into a look-ahead queue and serves
// pop requests. Define PIECE_SCHED_NO_REPEAT_EN to reject back-to-back repeats.
module piece_scheduler
    import tetris_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int PW    = PIECE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          rand_in,
    input  logic                pop,
    output logic [PW-1:0]       piece_out,
    output logic                piece_valid,
    output logic [PW*DEPTH-1:0] preview,
    output logic [2:0]          count,
    output logic                full
);

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    sched_state_t  state, state_next;
    logic          pend;
    logic          accept;
    logic          push;
    logic          sample_ok;
    logic [2:0]    count_after;
    logic [2:0]    count_next;
    logic [PW-1:0] sample;

    assign sample = PW'(rand_in);
    assign full   = (count == DEPTH_C);

`ifdef PIECE_SCHED_NO_REPEAT_EN
    logic [PW-1:0] last_piece;

    // The most recently written piece is the tail, or the last delivered
    // piece once the queue has drained.
    always_comb begin
        last_piece = piece_out;
        for (int i = 0; i < DEPTH; i++) begin
            if (3'(i + 1) == count) begin
                last_piece = preview[i*PW +: PW];
            end
        end
    end

    assign sample_ok = (sample != '0) && (sample != last_piece);
`else
    assign sample_ok = (sample != '0);
`endif

    always_comb begin
        accept      = (pop | pend) && (count != 3'd0);
        count_after = count - {2'b00, accept};
        // A pop from a full queue reopens a slot in the same cycle.
        push        = sample_ok && (count_after < DEPTH_C)
                      && ((state == S_FILL) || accept);
        count_next  = count_after + {2'b00, push};

        state_next = state;
        unique case (state)
            S_FILL: if (!accept && count_next == DEPTH_C) state_next = S_FULL;
            S_FULL: if (accept) state_next = S_FILL;
            default: state_next = S_FILL;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_FILL;
            pend        <= 1'b0;
            piece_out   <= '0;
            piece_valid <= 1'b0;
        end else begin
            state       <= state_next;
            pend        <= !accept && (pend | pop);
            piece_valid <= accept;
            if (accept) begin
                piece_out <= preview[PW-1:0];
            end
        end
    end

    piece_fifo #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (accept),
        .wdata (sample),
        .slots (preview),
        .count (count)
    );

endmodule

// File: tb/tb_piece_scheduler.sv
// Directed and randomized bench for piece_scheduler against a queue model.
module tb_piece_scheduler;

    localparam int DEPTH = 3;
    localparam int PW    = 3;
`ifdef PIECE_SCHED_NO_REPEAT_EN
    localparam bit NOREP = 1'b1;
`else
    localparam bit NOREP = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic [2:0]          rand_in;
    logic                pop;
    logic [PW-1:0]       piece_out;
    logic                piece_valid;
    logic [PW*DEPTH-1:0] preview;
    logic [2:0]          count;
    logic                full;

    int n_pass  = 0;
    int n_total = 0;

    int         mq[$];
    logic [2:0] m_out;
    logic       m_valid;
    logic       m_pend;

    piece_scheduler #(.DEPTH(DEPTH), .PW(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .rand_in     (rand_in),
        .pop         (pop),
        .piece_out   (piece_out),
        .piece_valid (piece_valid),
        .preview     (preview),
        .count       (count),
        .full        (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: a plain queue updated by the stated rules, one call per clock.
    task automatic model_update(input logic r, input logic [2:0] rv, input logic p);
        int last;
        bit acc;
        if (r) begin
            mq.delete();
            m_out   = 3'd0;
            m_valid = 1'b0;
            m_pend  = 1'b0;
        end else begin
            last = (mq.size() > 0) ? mq[$] : int'(m_out);
            acc  = (p || m_pend) && (mq.size() > 0);
            m_valid = acc;
            if (acc) m_out = 3'(mq.pop_front());
            m_pend = !acc && (p || m_pend);
            if (mq.size() < DEPTH && rv != 3'd0 && !(NOREP && int'(rv) == last))
                mq.push_back(int'(rv));
        end
    endtask

    function automatic logic [PW*DEPTH-1:0] model_preview();
        logic [PW*DEPTH-1:0] v;
        v = '0;
        for (int i = 0; i < mq.size(); i++) v[i*PW +: PW] = 3'(mq[i]);
        return v;
    endfunction

    task automatic check_model();
        check("valid",   32'(piece_valid), 32'(m_valid));
        check("out",     32'(piece_out),   32'(m_out));
        check("count",   32'(count),       32'(mq.size()));
        check("full",    32'(full),        32'(mq.size() == DEPTH));
        check("preview", 32'(preview),     32'(model_preview()));
    endtask

    task automatic step(input logic r, input logic [2:0] rv, input logic p);
        rst     = r;
        rand_in = rv;
        pop     = p;
        @(posedge clk);
        model_update(r, rv, p);
        #1;
        check_model();
    endtask

    int strobes;

    initial begin
        rst = 1'b1; rand_in = 3'd0; pop = 1'b0;
        step(1, 0, 0);
        step(1, 0, 0);
        check("rst_count",   32'(count),   32'd0);
        check("rst_preview", 32'(preview), 32'd0);
        check("rst_valid",   32'(piece_valid), 32'd0);

        // Reset fill: 1,2,3 land, 4 is ignored once full.
        step(0, 1, 0);
        step(0, 2, 0);
        step(0, 3, 0);
        step(0, 4, 0);
        check("fill_preview", 32'(preview), 32'({3'd3, 3'd2, 3'd1}));
        check("fill_full",    32'(full),    32'd1);

        // Single pop at full with a same-cycle refill.
        step(0, 5, 1);
        check("pop_out",     32'(piece_out),   32'd1);
        check("pop_valid",   32'(piece_valid), 32'd1);
        check("pop_preview", 32'(preview),     32'({3'd5, 3'd3, 3'd2}));
        step(0, 0, 0);
        check("pop_strobe_end", 32'(piece_valid), 32'd0);

        // Pop on empty: request held until the first valid sample.
        step(1, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 6, 0);
        check("empty_slot0", 32'(preview),     32'd6);
        check("empty_novld", 32'(piece_valid), 32'd0);
        step(0, 0, 0);
        check("empty_out",   32'(piece_out),   32'd6);
        check("empty_valid", 32'(piece_valid), 32'd1);
        step(0, 0, 0);
        check("empty_once",  32'(piece_valid), 32'd0);

        // Held pop for 10 cycles with the counter cycling.
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 2, 0);
        step(0, 3, 0);
        strobes = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 3'((k + 3) % 7 + 1), 1);
            if (piece_valid) strobes++;
            check("held_piece",    32'(piece_out),     32'(k % 7 + 1));
            check("held_nonempty", 32'(count != 3'd0), 32'd1);
        end
        check("held_strobes", 32'(strobes), 32'd10);
        step(0, 0, 0);

        // Mid-operation reset drops the pending request.
        step(1, 0, 0);
        step(0, 5, 1);
        check("mid_count_pre", 32'(count), 32'd1);
        step(1, 6, 0);
        check("mid_count",   32'(count),   32'd0);
        check("mid_preview", 32'(preview), 32'd0);
        step(0, 0, 0);
        step(0, 2, 0);
        step(0, 0, 0);
        check("mid_no_valid", 32'(piece_valid), 32'd0);
        check("mid_kept",     32'(count),       32'd1);

        // Repeat handling: 4,4,4 then 5.
        step(1, 0, 0);
        step(0, 4, 0);
        step(0, 4, 0);
        step(0, 4, 0);
        step(0, 5, 0);
        if (NOREP) check("repeat_preview", 32'(preview), 32'({3'd0, 3'd5, 3'd4}));
        else       check("repeat_preview", 32'(preview), 32'({3'd4, 3'd4, 3'd4}));

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 63) == 0),
                 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
